// File: rtl/id_pkg.sv
// Shared constants for the RV32I decode stage: opcodes, funct fields and the
// aluop/alusel encodings handed to EX.
package id_pkg;

  localparam int RegAddrLen = 5;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam int         F7_ALT_BIT = 30;

  // aluop = {alt, funct3} for ALU ops; memory/branch carry {0, funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [2:0] SEL_ALU    = 3'd0;
  localparam logic [2:0] SEL_LOAD   = 3'd1;
  localparam logic [2:0] SEL_STORE  = 3'd2;
  localparam logic [2:0] SEL_BRANCH = 3'd3;
  localparam logic [2:0] SEL_JUMP   = 3'd4;
  localparam logic [2:0] SEL_LUI    = 3'd5;
  localparam logic [2:0] SEL_AUIPC  = 3'd6;
  localparam logic [2:0] SEL_NONE   = 3'd7;

endpackage

// File: rtl/id_decoder.sv
// Combinational RV32I field decoder. rd is forced to 0 when the instruction
// does not write a register so EX never sees a stray destination.
module id_decoder
  import id_pkg::*;
(
  input  logic [31:0]           inst,
  output logic [31:0]           imm,
  output logic [RegAddrLen-1:0] rd,
  output logic                  rd_we,
  output logic                  rs1_en,
  output logic                  rs2_en,
  output logic [3:0]            aluop,
  output logic [2:0]            alusel,
  output logic                  illegal,
  output logic                  use_imm
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    imm     = ZERO_WORD;
    rd_we   = 1'b0;
    rs1_en  = 1'b0;
    rs2_en  = 1'b0;
    aluop   = ALU_ADD;
    alusel  = SEL_NONE;
    illegal = 1'b0;
    use_imm = 1'b0;
    case (opcode)
      OPC_R: begin
        rd_we  = 1'b1; rs1_en = 1'b1; rs2_en = 1'b1;
        aluop  = {inst[F7_ALT_BIT], funct3};
        alusel = SEL_ALU;
      end
      OPC_IMM: begin
        rd_we = 1'b1; rs1_en = 1'b1; use_imm = 1'b1;
        alusel = SEL_ALU;
        if (funct3 == F3_SLL || funct3 == F3_SR) begin
          imm   = {27'b0, inst[24:20]};
          aluop = {(funct3 == F3_SR) ? inst[F7_ALT_BIT] : 1'b0, funct3};
        end else begin
          imm   = imm_i;
          aluop = {1'b0, funct3};
        end
      end
      OPC_LOAD: begin
        rd_we = 1'b1; rs1_en = 1'b1; use_imm = 1'b1;
        imm = imm_i; aluop = {1'b0, funct3}; alusel = SEL_LOAD;
      end
      OPC_JALR: begin
        rd_we = 1'b1; rs1_en = 1'b1; use_imm = 1'b1;
        imm = imm_i; alusel = SEL_JUMP;
      end
      OPC_STORE: begin
        rs1_en = 1'b1; rs2_en = 1'b1;
        imm = imm_s; aluop = {1'b0, funct3}; alusel = SEL_STORE;
      end
      OPC_BRANCH: begin
        rs1_en = 1'b1; rs2_en = 1'b1;
        imm = imm_b; aluop = {1'b0, funct3}; alusel = SEL_BRANCH;
      end
      OPC_LUI: begin
        rd_we = 1'b1; use_imm = 1'b1; imm = imm_u; alusel = SEL_LUI;
      end
      OPC_AUIPC: begin
        rd_we = 1'b1; use_imm = 1'b1; imm = imm_u; alusel = SEL_AUIPC;
      end
      OPC_JAL: begin
        rd_we = 1'b1; use_imm = 1'b1; imm = imm_j; alusel = SEL_JUMP;
      end
      default: illegal = 1'b1;
    endcase
    rd = rd_we ? inst[11:7] : '0;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with forwarding priority mux, load-use interlock and the
// ID/EX output register behind a valid/ready handshake.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NUM_FW = 2,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_inst,
  output logic [RegAddrLen-1:0]      rs1_addr,
  output logic [RegAddrLen-1:0]      rs2_addr,
  output logic                       rs1_en,
  output logic                       rs2_en,
  input  logic [XLEN-1:0]            rs1_data,
  input  logic [XLEN-1:0]            rs2_data,
  input  logic [NUM_FW-1:0]          fw_valid,
  input  logic [NUM_FW-1:0]          fw_is_load,
  input  logic [5*NUM_FW-1:0]        fw_addr,
  input  logic [XLEN*NUM_FW-1:0]     fw_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_op1,
  output logic [XLEN-1:0]            out_op2,
  output logic [XLEN-1:0]            out_imm,
  output logic [RegAddrLen-1:0]      out_rd,
  output logic                       out_rd_we,
  output logic [3:0]                 out_aluop,
  output logic [2:0]                 out_alusel,
  output logic                       out_illegal,
  output logic [CNT_W-1:0]           stall_cnt
);

  typedef struct packed {
    logic            hit;
    logic            load;
    logic [XLEN-1:0] data;
  } fw_pick_t;

  // Scan from the oldest channel down so the youngest match overwrites.
  function automatic fw_pick_t fw_pick(input logic [RegAddrLen-1:0] rs,
                                       input logic [NUM_FW-1:0] v,
                                       input logic [NUM_FW-1:0] l,
                                       input logic [5*NUM_FW-1:0] a,
                                       input logic [XLEN*NUM_FW-1:0] d);
    fw_pick_t r;
    r = '0;
    for (int i = NUM_FW - 1; i >= 0; i--) begin
      if (rs != '0 && v[i] && a[5*i +: 5] == rs) begin
        r.hit  = 1'b1;
        r.load = l[i];
        r.data = d[XLEN*i +: XLEN];
      end
    end
    return r;
  endfunction

  logic [31:0]           dec_imm;
  logic [RegAddrLen-1:0] dec_rd;
  logic                  dec_rd_we, dec_illegal, dec_use_imm;
  logic [3:0]            dec_aluop;
  logic [2:0]            dec_alusel;
  logic [XLEN-1:0]       imm_x, op1, op2_src, op2;
  fw_pick_t              pick1, pick2;
  logic                  hazard, accept;

  id_decoder u_dec (
    .inst    (in_inst),
    .imm     (dec_imm),
    .rd      (dec_rd),
    .rd_we   (dec_rd_we),
    .rs1_en  (rs1_en),
    .rs2_en  (rs2_en),
    .aluop   (dec_aluop),
    .alusel  (dec_alusel),
    .illegal (dec_illegal),
    .use_imm (dec_use_imm)
  );

  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];
  assign imm_x    = XLEN'($signed(dec_imm));

  assign pick1 = fw_pick(rs1_addr, fw_valid, fw_is_load, fw_addr, fw_data);
  assign pick2 = fw_pick(rs2_addr, fw_valid, fw_is_load, fw_addr, fw_data);

  assign op1     = (!rs1_en || rs1_addr == '0) ? '0 : (pick1.hit ? pick1.data : rs1_data);
  assign op2_src = (!rs2_en || rs2_addr == '0) ? '0 : (pick2.hit ? pick2.data : rs2_data);
  assign op2     = dec_use_imm ? imm_x : op2_src;

  assign hazard   = (rs1_en && pick1.hit && pick1.load) || (rs2_en && pick2.hit && pick2.load);
  assign in_ready = rst && !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_aluop   <= '0;
      out_alusel  <= '0;
      out_illegal <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        out_op1     <= op1;
        out_op2     <= op2;
        out_imm     <= imm_x;
        out_rd      <= dec_rd;
        out_rd_we   <= dec_rd_we;
        out_aluop   <= dec_aluop;
        out_alusel  <= dec_alusel;
        out_illegal <= dec_illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid && hazard && !flush && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode stage with a built-in ID/EX output register. It replaces the purely combinational decoder between the IF/ID register and EX. It decodes RV32I, selects operands across NUM_FW prioritised forwarding channels, and interlocks on load-use hazards. Valid/ready handshakes on both sides, a flush input and a saturating stall counter let it sit in a back-pressured pipeline.

## Interface
Parameters:
- XLEN, 32, register/data width
- NUM_FW, 2, forwarding channels; index 0 = youngest producer, highest priority
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- flush  in  1  kill in-flight and held instruction
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  XLEN  instruction address
- in_inst  in  32  instruction word
- rs1_addr, rs2_addr  out  5 each  regfile read addresses (inst[19:15], inst[24:20])
- rs1_en, rs2_en  out  1 each  regfile read enables
- rs1_data, rs2_data  in  XLEN each  regfile read data
- fw_valid  in  NUM_FW  channel i carries a pending write
- fw_is_load  in  NUM_FW  channel i value not yet available (load in EX)
- fw_addr  in  5*NUM_FW  channel i destination, slice [5i+4:5i]
- fw_data  in  XLEN*NUM_FW  channel i value
- out_valid  out  1  ID/EX payload valid
- out_ready  in  1  EX consumes payload
- out_pc, out_op1, out_op2, out_imm  out  XLEN each  registered payload
- out_rd  out  5  destination
- out_rd_we  out  1  destination write enable
- out_aluop  out  4  operation code
- out_alusel  out  3  operation class
- out_illegal  out  1  opcode not recognised
- stall_cnt  out  CNT_W  cycles lost to load-use interlock

## Operation
- Decode: RV32I opcodes R, I-ALU, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL; immediates sign-extended per format.
- Shift-immediates: out_imm = zero-extended inst[24:20]. STORE/BRANCH: offset on out_imm, op2 = rs2.
- Unknown opcode: out_illegal=1, out_rd_we=0, both read enables 0. Still passed downstream.
- Operand select per source, when its read enable is set:
  - Address 0 gives 0 and never matches a forwarding channel.
  - Otherwise take the lowest-index channel with fw_valid && fw_addr==rs.
  - If no channel matches, take regfile data.
  - A disabled rs gives 0.
- op2 = out_imm for I/U/J-type instructions.
- hazard = a winning channel has fw_is_load=1, on either enabled source. A lower-priority non-load match does not clear it.
- in_ready = rst && !flush && !hazard && (!out_valid || out_ready).
- Register update, priority order:
  1. reset
  2. flush: out_valid←0
  3. accept (in_valid && in_ready): payload loaded, out_valid←1
  4. out_ready (no accept): out_valid←0
  5. otherwise hold
- stall_cnt increments when in_valid && hazard && !flush. Saturates at all-ones.

## Timing
- Reset: every output register and stall_cnt = 0. in_ready = 0 while rst=0.
- Latency: one cycle from accept edge to out_valid=1.
- Forwarding and hazard are combinational in the accept cycle. Payload is sampled at the edge.
- Back-to-back: with out_ready=1 held, one instruction per cycle.
- Back-pressure: while out_valid && !out_ready, payload is stable and in_ready=0.
- Load-use: hazard stalls until the channel drops fw_is_load. If EX drains meanwhile, a bubble appears (out_valid=0).
- Flush coincident with accept: flush wins, the instruction is dropped, stall_cnt is not incremented.
- Reset mid-stall clears the counter and payload. No instruction is replayed.

## Structure
- Package id_pkg: opcode, funct3 and funct7-bit constants; aluop/alusel encodings; RegAddrLen=5; ZERO_WORD.
- Sub-module id_decoder (combinational): inst → imm, rd, rd_we, rs enables, aluop, alusel, illegal, use_imm.
- Forwarding priority mux and output register live in id_stage_pipe.

## Test plan
- ADDI x5,x0,7 (0x00700293), no forwarding, out_ready=1 → next cycle out_valid=1, out_op1=0, out_op2=7, out_rd=5, out_rd_we=1.
- ADD x3,x1,x2 with fw0={valid,x1,0xAAAA}, fw1={valid,x1,0xBBBB}, regfile x2=5 → out_op1=0xAAAA, out_op2=5.
- Same ADD, fw0={valid,load,x2} for 3 cycles → in_ready=0 for 3 cycles, stall_cnt=3, one bubble, accepted on cycle 4.
- ADD x3,x0,x0 with fw0={valid,load,x0} → no stall, operands 0.
- out_ready=0 for 4 cycles after accept → payload unchanged, in_ready=0; flush in cycle 2 → out_valid=0 next edge.
- Opcode 0x7F → out_illegal=1, out_rd_we=0. CNT_W=2, 5 hazard cycles → stall_cnt=3.
